// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the 16-point FFT frame sequencer.
package fft_pkg;

  localparam int unsigned N_POINTS = 16;
  localparam int unsigned IDX_W    = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_START,
    S_WAIT,
    S_HOLD
  } seq_state_t;

endpackage

// File: rtl/fft_out_serializer.sv
// Output side of the FFT sequencer: captures the 16 core bins and replays them
// as an indexed valid/ready stream, counting fully drained frames.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      capture_i,
  input  logic [N_POINTS*WIDTH-1:0] bins_real_i,
  input  logic [N_POINTS*WIDTH-1:0] bins_imag_i,
  input  logic                      m_ready,
  output logic                      m_valid,
  output logic [WIDTH-1:0]          m_real,
  output logic [WIDTH-1:0]          m_imag,
  output logic [IDX_W-1:0]          m_index,
  output logic                      m_last,
  output logic                      free_o,
  output logic [15:0]               frame_count
);

  logic [WIDTH-1:0] out_re_q [N_POINTS];
  logic [WIDTH-1:0] out_im_q [N_POINTS];
  logic [IDX_W-1:0] out_cnt_q;
  logic             m_valid_q;
  logic [15:0]      frame_count_q;

  logic accept;
  logic drain_last;

  assign accept     = m_valid_q && m_ready;
  assign drain_last = accept && (out_cnt_q == LAST_IDX);
  // Freeing on the final accepted bin lets a waiting frame load with no bubble.
  assign free_o     = !m_valid_q || drain_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_POINTS; k++) begin
        out_re_q[k] <= '0;
        out_im_q[k] <= '0;
      end
      out_cnt_q     <= '0;
      m_valid_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      if (capture_i) begin
        for (int unsigned k = 0; k < N_POINTS; k++) begin
          out_re_q[k] <= bins_real_i[WIDTH*k +: WIDTH];
          out_im_q[k] <= bins_imag_i[WIDTH*k +: WIDTH];
        end
        out_cnt_q <= '0;
        m_valid_q <= 1'b1;
      end else if (accept) begin
        out_cnt_q <= out_cnt_q + 1'b1;
        if (out_cnt_q == LAST_IDX) begin
          m_valid_q <= 1'b0;
        end
      end
      if (drain_last) begin
        frame_count_q <= frame_count_q + 1'b1;
      end
    end
  end

  assign m_valid     = m_valid_q;
  assign m_real      = out_re_q[out_cnt_q];
  assign m_imag      = out_im_q[out_cnt_q];
  assign m_index     = out_cnt_q;
  assign m_last      = m_valid_q && (out_cnt_q == LAST_IDX);
  assign frame_count = frame_count_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Streaming front/back end for the 16-point FFT core: gathers a frame, starts the
// core, hands results to the serializer. Optional watchdog: FFT_SEQ_TIMEOUT_EN.
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = 16
`ifdef FFT_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WIDTH-1:0]          s_real,
  input  logic [WIDTH-1:0]          s_imag,
  output logic                      fft_start,
  output logic [N_POINTS*WIDTH-1:0] fft_in_real,
  output logic [N_POINTS*WIDTH-1:0] fft_in_imag,
  input  logic                      fft_done,
  input  logic [N_POINTS*WIDTH-1:0] fft_out_real,
  input  logic [N_POINTS*WIDTH-1:0] fft_out_imag,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [WIDTH-1:0]          m_real,
  output logic [WIDTH-1:0]          m_imag,
  output logic [IDX_W-1:0]          m_index,
  output logic                      m_last,
  output logic                      busy,
  output logic [15:0]               frame_count
`ifdef FFT_SEQ_TIMEOUT_EN
  ,
  output logic                      err_timeout
`endif
);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] in_cnt_q, in_cnt_d;
  logic [WIDTH-1:0] in_re_q [N_POINTS];
  logic [WIDTH-1:0] in_im_q [N_POINTS];

  logic accept_in;
  logic capture;
  logic out_free;

`ifdef FFT_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt_q;
  logic            wd_hit;

  assign wd_hit = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end else begin
      wd_cnt_q <= '0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FILL;
      in_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_POINTS; k++) begin
        in_re_q[k] <= '0;
        in_im_q[k] <= '0;
      end
    end else if (accept_in) begin
      in_re_q[in_cnt_q] <= s_real;
      in_im_q[in_cnt_q] <= s_imag;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    case (state_q)
      S_FILL: begin
        if (accept_in) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == LAST_IDX) begin
            state_d = S_START;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (fft_done) begin
          if (out_free) begin
            state_d  = S_FILL;
            in_cnt_d = '0;
          end else begin
            state_d = S_HOLD;
          end
        end
`ifdef FFT_SEQ_TIMEOUT_EN
        else if (wd_hit) begin
          state_d  = S_FILL;
          in_cnt_d = '0;
        end
`endif
      end
      S_HOLD: begin
        if (out_free) begin
          state_d  = S_FILL;
          in_cnt_d = '0;
        end
      end
      default: begin
        state_d  = S_FILL;
        in_cnt_d = '0;
      end
    endcase
  end

  // s_ready is masked by rst so every output reads 0 while reset is held.
  always_comb begin
    s_ready   = (state_q == S_FILL) && !rst;
    fft_start = (state_q == S_START);
    capture   = (((state_q == S_WAIT) && fft_done) || (state_q == S_HOLD)) && out_free;
`ifdef FFT_SEQ_TIMEOUT_EN
    err_timeout = (state_q == S_WAIT) && !fft_done && wd_hit;
`endif
  end

  assign accept_in = s_valid && s_ready;
  assign busy      = !((state_q == S_FILL) && (in_cnt_q == '0)) || m_valid;

  always_comb begin
    fft_in_real = '0;
    fft_in_imag = '0;
    for (int unsigned k = 0; k < N_POINTS; k++) begin
      fft_in_real[WIDTH*k +: WIDTH] = in_re_q[k];
      fft_in_imag[WIDTH*k +: WIDTH] = in_im_q[k];
    end
  end

  fft_out_serializer #(
    .WIDTH(WIDTH)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .capture_i  (capture),
    .bins_real_i(fft_out_real),
    .bins_imag_i(fft_out_imag),
    .m_ready    (m_ready),
    .m_valid    (m_valid),
    .m_real     (m_real),
    .m_imag     (m_imag),
    .m_index    (m_index),
    .m_last     (m_last),
    .free_o     (out_free),
    .frame_count(frame_count)
  );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer with a bin-reversing core stub and
// a queue-based reference of the expected output stream.
module tb_fft_frame_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned N     = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_real = '0;
  logic [WIDTH-1:0] s_imag = '0;
  logic             fft_start;
  logic [N*WIDTH-1:0] fft_in_real, fft_in_imag;
  logic             fft_done;
  logic [N*WIDTH-1:0] fft_out_real, fft_out_imag;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_real, m_imag;
  logic [3:0]       m_index;
  logic             m_last;
  logic             busy;
  logic [15:0]      frame_count;
`ifdef FFT_SEQ_TIMEOUT_EN
  logic             err_timeout;
`endif

  always #5 clk = ~clk;

  fft_frame_sequencer #(
    .WIDTH(WIDTH)
`ifdef FFT_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
    .fft_start(fft_start), .fft_in_real(fft_in_real), .fft_in_imag(fft_in_imag),
    .fft_done(fft_done), .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_index(m_index), .m_last(m_last), .busy(busy), .frame_count(frame_count)
`ifdef FFT_SEQ_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Core stub: bin k of the result is input sample 15-k; done rises lat cycles after start.
  int unsigned lat = 4;
  bit          never_done = 1'b0;
  int unsigned lat_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fft_done     <= 1'b0;
      lat_cnt      <= 0;
      fft_out_real <= '0;
      fft_out_imag <= '0;
    end else if (fft_start) begin
      for (int k = 0; k < N; k++) begin
        fft_out_real[WIDTH*k +: WIDTH] <= fft_in_real[WIDTH*(N-1-k) +: WIDTH];
        fft_out_imag[WIDTH*k +: WIDTH] <= fft_in_imag[WIDTH*(N-1-k) +: WIDTH];
      end
      fft_done <= 1'b0;
      lat_cnt  <= lat;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1 && !never_done) fft_done <= 1'b1;
    end
  end

  // Downstream ready pattern: 0 off, 1 on, 2 toggle, 3 random.
  int unsigned rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      2:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  longint cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    logic [3:0]       idx;
    logic             last;
  } bin_t;

  logic [WIDTH-1:0] cur_re[$], cur_im[$];
  bin_t             exp_q[$];
  bin_t             nb, ob;
  int unsigned      drained = 0;
  int unsigned      starts = 0;
  bit               start_due = 0, fc_due = 0, prev_stall = 0, overlap_seen = 0;
  logic [WIDTH-1:0] prev_re, prev_im;
  logic [3:0]       prev_idx;
  longint           start_cyc = 0;
`ifdef FFT_SEQ_TIMEOUT_EN
  longint           to_cyc = 0;
  int unsigned      timeouts = 0;
  bit               rdy_due = 0;
`endif

  // Reference model: frames of 16 accepted samples become 16 reversed bins,
  // delivered in order; a stall must freeze the presented bin.
  always @(negedge clk) begin
    if (rst) begin
      cur_re.delete(); cur_im.delete(); exp_q.delete();
      drained = 0; start_due = 0; fc_due = 0; prev_stall = 0;
    end else begin
      if (start_due) begin
        check_eq("start_latency", fft_start, 1);
        start_due = 0;
      end else if (fft_start) begin
        check_eq("start_spurious", fft_start, 0);
      end
      if (fft_start) begin
        starts++;
        start_cyc = cyc;
      end
      if (fc_due) begin
        check_eq("frame_count", frame_count, drained);
        fc_due = 0;
      end
`ifdef FFT_SEQ_TIMEOUT_EN
      if (rdy_due) begin
        check_eq("timeout_s_ready", s_ready, 1);
        rdy_due = 0;
      end
      if (err_timeout) begin
        timeouts++;
        to_cyc  = cyc;
        rdy_due = 1;
        for (int k = 0; k < N && exp_q.size() > 0; k++) void'(exp_q.pop_back());
      end
`endif
      if (prev_stall) begin
        check_eq("stall_valid", m_valid, 1);
        check_eq("stall_real", m_real, prev_re);
        check_eq("stall_imag", m_imag, prev_im);
        check_eq("stall_index", m_index, prev_idx);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("out_spurious", m_valid, 0);
        end else begin
          ob = exp_q.pop_front();
          check_eq("out_real", m_real, ob.re);
          check_eq("out_imag", m_imag, ob.im);
          check_eq("out_index", m_index, ob.idx);
          check_eq("out_last", m_last, ob.last);
          if (ob.last) begin
            drained++;
            fc_due = 1;
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_re    = m_real;
      prev_im    = m_imag;
      prev_idx   = m_index;
      if (s_valid && s_ready) begin
        if (m_valid) overlap_seen = 1;
        cur_re.push_back(s_real);
        cur_im.push_back(s_imag);
        if (cur_re.size() == N) begin
          for (int k = 0; k < N; k++) begin
            nb.re   = cur_re[N-1-k];
            nb.im   = cur_im[N-1-k];
            nb.idx  = 4'(k);
            nb.last = (k == N - 1);
            exp_q.push_back(nb);
          end
          cur_re.delete();
          cur_im.delete();
          start_due = 1;
        end
      end
    end
  end

  task automatic drive_beat(input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im,
                            input int unsigned gap);
    int unsigned n;
    s_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_real  = re;
    s_imag  = im;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 500) begin
        check_eq("input_wait", s_ready, 1);
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_beats(input int unsigned nbeats, input bit impulse, input int unsigned maxgap);
    for (int unsigned i = 0; i < nbeats; i++) begin
      if (impulse) drive_beat((i == 0) ? 16'sd32767 : '0, '0, 0);
      else drive_beat(WIDTH'($urandom), WIDTH'($urandom), $urandom_range(0, maxgap));
    end
  endtask

  task automatic wait_drain(input string tag);
    int unsigned n = 0;
    while (n < 2000 && (exp_q.size() != 0 || m_valid)) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_fft_start", fft_start, 0);
    check_eq("rst_fft_in", |{fft_in_real, fft_in_imag}, 0);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_data", {m_real, m_imag}, 0);
    check_eq("rst_m_index", m_index, 0);
    check_eq("rst_m_last", m_last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_count", frame_count, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_s_ready", s_ready, 1);
    check_eq("idle_busy", busy, 0);
    @(posedge clk); #1;

    // Impulse
    rdy_mode = 1; lat = 4;
    send_beats(N, 1'b1, 0);
    wait_drain("t1_drain");
    check_eq("t1_starts", starts, 1);
    check_eq("t1_frame_count", frame_count, 1);

    // Backpressure
    rdy_mode = 2;
    send_beats(N, 1'b0, 2);
    wait_drain("t2_drain");
    check_eq("t2_frame_count", frame_count, 2);

    // Overlapped frames
    rdy_mode = 1; lat = 2; overlap_seen = 0;
    send_beats(3 * N, 1'b0, 0);
    wait_drain("t3_drain");
    check_eq("t3_frame_count", frame_count, 5);
    check_eq("t3_starts", starts, 5);
    check_eq("t3_overlap", overlap_seen, 1);

    // Hold: second result waits until the first frame drains
    rdy_mode = 0; lat = 3;
    send_beats(2 * N, 1'b0, 1);
    repeat (lat + 6) @(posedge clk);
    @(negedge clk);
    check_eq("t4_s_ready", s_ready, 0);
    check_eq("t4_m_valid", m_valid, 1);
    check_eq("t4_m_index", m_index, 0);
    check_eq("t4_busy", busy, 1);
    @(posedge clk); #1;
    rdy_mode = 1;
    wait_drain("t4_drain");
    check_eq("t4_frame_count", frame_count, 7);

    // Reset in the middle of a frame
    rdy_mode = 3;
    send_beats(7, 1'b0, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    send_beats(N, 1'b0, 1);
    wait_drain("t5_drain");
    check_eq("t5_frame_count", frame_count, 1);

`ifdef FFT_SEQ_TIMEOUT_EN
    // Watchdog: core never completes
    rdy_mode = 1; never_done = 1'b1; timeouts = 0;
    send_beats(N, 1'b0, 0);
    for (int n = 0; n < 100 && timeouts == 0; n++) @(negedge clk);
    check_eq("t6_timeout_seen", timeouts, 1);
    check_eq("t6_timeout_delay", 32'(to_cyc - start_cyc), 16);
    repeat (3) @(negedge clk);
    check_eq("t6_frame_count", frame_count, 1);
    check_eq("t6_dropped", exp_q.size(), 0);
    never_done = 1'b0;
`endif

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=0x0 exp=0x1");
    $fatal(1, "simulation time limit reached");
  end

endmodule
